// File: rtl/window_gen_3x3.sv
// Raster-scan 3x3 window generator: two line RAMs plus a 3x3 shift array.
// Emits interior windows only, one cycle after the pixel that completes each window.
module window_gen_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  input  logic              iSof,
  input  logic [DATA_W-1:0] iPixel,
  output logic [DATA_W-1:0] oP11,
  output logic [DATA_W-1:0] oP12,
  output logic [DATA_W-1:0] oP13,
  output logic [DATA_W-1:0] oP21,
  output logic [DATA_W-1:0] oP22,
  output logic [DATA_W-1:0] oP23,
  output logic [DATA_W-1:0] oP31,
  output logic [DATA_W-1:0] oP32,
  output logic [DATA_W-1:0] oP33,
  output logic              oValid,
  output logic              oEof
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } stateT;

  stateT             stateR;
  logic [COL_W-1:0]  colR;
  logic [ROW_W-1:0]  rowR;

  logic [DATA_W-1:0] lb0Mem [IMG_W];
  logic [DATA_W-1:0] lb1Mem [IMG_W];
  logic [DATA_W-1:0] lb0RdR;
  logic [DATA_W-1:0] lb1RdR;

  logic              acceptS;
  logic              lastColS;
  logic              lastRowS;
  logic [COL_W-1:0]  nextColS;
  logic [COL_W-1:0]  rdAddrS;
  logic [COL_W-1:0]  wrAddrS;
  logic              winS;
  logic              eofS;

  // Pixel acceptance, next-column prediction and window-emit decode.
  always_comb begin
    acceptS  = iValid && (iSof || (stateR != IDLE));
    lastColS = (colR == LAST_COL);
    lastRowS = (rowR == LAST_ROW);
    wrAddrS  = iSof ? COL_W'(0) : colR;

    if (iSof) begin
      nextColS = COL_W'(1);
    end else if (lastColS) begin
      nextColS = COL_W'(0);
    end else begin
      nextColS = colR + COL_W'(1);
    end

    // Prefetch the column the next accepted pixel will use, so the synchronous
    // RAM read is already waiting when that pixel arrives.
    if (acceptS) begin
      rdAddrS = nextColS;
    end else begin
      rdAddrS = colR;
    end

    winS = acceptS && !iSof && (stateR == RUN) && (colR >= COL_W'(2));
    eofS = winS && lastColS && lastRowS;
  end

  // Line RAMs: registered read of the prefetched column, write on accept.
  always_ff @(posedge iClk) begin
    lb0RdR <= lb0Mem[rdAddrS];
    lb1RdR <= lb1Mem[rdAddrS];
    if (acceptS) begin
      lb1Mem[wrAddrS] <= lb0RdR;
      lb0Mem[wrAddrS] <= iPixel;
    end
  end

  // Frame FSM, raster counters, window shift array and output flags.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateR <= IDLE;
      colR   <= COL_W'(0);
      rowR   <= ROW_W'(0);
      oP11   <= DATA_W'(0);
      oP12   <= DATA_W'(0);
      oP13   <= DATA_W'(0);
      oP21   <= DATA_W'(0);
      oP22   <= DATA_W'(0);
      oP23   <= DATA_W'(0);
      oP31   <= DATA_W'(0);
      oP32   <= DATA_W'(0);
      oP33   <= DATA_W'(0);
      oValid <= 1'b0;
      oEof   <= 1'b0;
    end else begin
      oValid <= winS;
      oEof   <= eofS;
      if (acceptS) begin
        oP11 <= oP12;
        oP12 <= oP13;
        oP13 <= lb1RdR;
        oP21 <= oP22;
        oP22 <= oP23;
        oP23 <= lb0RdR;
        oP31 <= oP32;
        oP32 <= oP33;
        oP33 <= iPixel;
        colR <= nextColS;
        if (iSof) begin
          rowR   <= ROW_W'(0);
          stateR <= FILL;
        end else begin
          case (stateR)
            FILL: begin
              if (lastColS) begin
                rowR <= rowR + ROW_W'(1);
                if (rowR == ROW_W'(1)) begin
                  stateR <= RUN;
                end
              end
            end
            RUN: begin
              if (lastColS) begin
                if (lastRowS) begin
                  rowR   <= ROW_W'(0);
                  stateR <= IDLE;
                end else begin
                  rowR <= rowR + ROW_W'(1);
                end
              end
            end
            default: begin
              colR   <= COL_W'(0);
              rowR   <= ROW_W'(0);
              stateR <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on a 5x4 frame with pixel = base + row*16 + col.
module tb_window_gen_3x3;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  typedef logic [9*DW:0] winT;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iValid;
  logic          iSof;
  logic [DW-1:0] iPixel;
  logic [DW-1:0] oP11, oP12, oP13, oP21, oP22, oP23, oP31, oP32, oP33;
  logic          oValid;
  logic          oEof;

  winT expQ[$];
  int  checks    = 0;
  int  errors    = 0;
  int  winCount  = 0;
  int  eofCount  = 0;
  int  c0;
  int  e0;

  window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iSof(iSof), .iPixel(iPixel),
    .oP11(oP11), .oP12(oP12), .oP13(oP13),
    .oP21(oP21), .oP22(oP22), .oP23(oP23),
    .oP31(oP31), .oP32(oP32), .oP33(oP33),
    .oValid(oValid), .oEof(oEof)
  );

  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic winT expWin(input int base, input int r, input int x);
    winT w;
    logic [DW-1:0] v;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v = 8'(base + (r - 2 + i) * 16 + (x - 2 + j));
        w = {w[8*DW:0], v};
      end
    end
    w[9*DW] = (r == H - 1) && (x == W - 1);
    return w;
  endfunction

  task automatic sendPixel(input int r, input int x, input int base, input logic sof, input logic model);
    iValid = 1'b1;
    iSof   = sof;
    iPixel = 8'(base + r * 16 + x);
    if (model && r >= 2 && x >= 2) expQ.push_back(expWin(base, r, x));
    @(negedge iClk);
    iValid = 1'b0;
    iSof   = 1'b0;
  endtask

  task automatic sendFrame(input int base, input logic gaps);
    for (int r = 0; r < H; r++) begin
      for (int x = 0; x < W; x++) begin
        sendPixel(r, x, base, (r == 0) && (x == 0), 1'b1);
        if (gaps) @(negedge iClk);
      end
    end
  endtask

  always @(negedge iClk) begin : monitor
    winT e;
    if (oValid === 1'b1) begin
      winCount++;
      if (oEof) eofCount++;
      if (expQ.size() == 0) begin
        checkVal("unexpectedValid", 80'(oValid), 80'd0);
      end else begin
        e = expQ.pop_front();
        checkVal("window", 80'({oEof, oP11, oP12, oP13, oP21, oP22, oP23, oP31, oP32, oP33}), 80'(e));
      end
    end
  end

  initial begin
    iRst = 1'b1; iValid = 1'b0; iSof = 1'b0; iPixel = 8'd0;
    repeat (2) @(negedge iClk);
    checkVal("rstValid", 80'(oValid), 80'd0);
    checkVal("rstEof", 80'(oEof), 80'd0);
    checkVal("rstWin", 80'({oP11, oP12, oP13, oP21, oP22, oP23, oP31, oP32, oP33}), 80'd0);
    iRst = 1'b0;
    @(negedge iClk);

    // continuous frame
    c0 = winCount; e0 = eofCount;
    sendFrame(0, 1'b0);
    repeat (2) @(negedge iClk);
    checkVal("t1Count", 80'(winCount - c0), 80'd6);
    checkVal("t1Eof", 80'(eofCount - e0), 80'd1);

    // iValid low every other cycle
    c0 = winCount; e0 = eofCount;
    sendFrame(0, 1'b1);
    repeat (2) @(negedge iClk);
    checkVal("t2Count", 80'(winCount - c0), 80'd6);
    checkVal("t2Eof", 80'(eofCount - e0), 80'd1);

    // pixels before any iSof are dropped
    c0 = winCount;
    for (int k = 0; k < 12; k++) sendPixel(2 + k / W, k % W, 8'h40, 1'b0, 1'b0);
    repeat (2) @(negedge iClk);
    checkVal("t3NoValid", 80'(winCount - c0), 80'd0);
    c0 = winCount;
    sendFrame(0, 1'b0);
    repeat (2) @(negedge iClk);
    checkVal("t3Count", 80'(winCount - c0), 80'd6);

    // reset during row 2
    c0 = winCount;
    for (int r = 0; r < 2; r++)
      for (int x = 0; x < W; x++) sendPixel(r, x, 0, (r == 0) && (x == 0), 1'b1);
    for (int x = 0; x < 4; x++) sendPixel(2, x, 0, 1'b0, 1'b1);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    checkVal("t4RstValid", 80'(oValid), 80'd0);
    checkVal("t4RstWin", 80'({oP11, oP12, oP13, oP21, oP22, oP23, oP31, oP32, oP33}), 80'd0);
    sendFrame(0, 1'b0);
    repeat (2) @(negedge iClk);
    checkVal("t4Count", 80'(winCount - c0), 80'd8);

    // iSof mid-frame at row 1 col 3
    c0 = winCount;
    for (int x = 0; x < W; x++) sendPixel(0, x, 8'h60, x == 0, 1'b1);
    for (int x = 0; x < 3; x++) sendPixel(1, x, 8'h60, 1'b0, 1'b1);
    sendFrame(0, 1'b0);
    repeat (2) @(negedge iClk);
    checkVal("t5Count", 80'(winCount - c0), 80'd6);

    // back-to-back frames
    c0 = winCount; e0 = eofCount;
    sendFrame(0, 1'b0);
    sendFrame(8'h80, 1'b0);
    repeat (3) @(negedge iClk);
    checkVal("t6Count", 80'(winCount - c0), 80'd12);
    checkVal("t6Eof", 80'(eofCount - e0), 80'd2);

    checkVal("sbEmpty", 80'(expQ.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
